// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register, flag register, branch condition resolve and sticky halt.
// 1-cycle latency; stall holds everything, flush loads a bubble. EX_FLAG_BYPASS_EN lets cond_true see next-state flags.
`timescale 1ns/1ps
module ex_mem_stage #(
  parameter int          DATA_W   = 16,
  parameter int          RADDR_W  = 4,
  parameter logic [2:0]  FLAG_RST = 3'b000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               ex_valid,
  input  logic [3:0]         ex_opcode,
  input  logic [DATA_W-1:0]  ex_result,
  input  logic [DATA_W-1:0]  ex_addr,
  input  logic [2:0]         ex_flag,
  input  logic [DATA_W-1:0]  ex_pcs_val,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic               ex_reg_we,
  input  logic               ex_mem_re,
  input  logic               ex_mem_we,
  input  logic [2:0]         br_ccc,
  output logic               mem_valid,
  output logic [3:0]         mem_opcode,
  output logic [DATA_W-1:0]  mem_result,
  output logic [DATA_W-1:0]  mem_addr,
  output logic [RADDR_W-1:0] mem_rd,
  output logic               mem_reg_we,
  output logic               mem_mem_re,
  output logic               mem_mem_we,
  output logic [2:0]         flags,
  output logic               cond_true,
  output logic               halted
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_PCS = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  logic       accept;
  logic       cap_valid;
  logic [2:0] flags_nxt;
  logic [2:0] flag_src;

  assign accept    = ex_valid & ~stall & ~flush & ~halted;
  assign cap_valid = ex_valid & ~halted;

  always_comb begin
    flags_nxt = flags;
    if (accept) begin
      case (ex_opcode)
        OP_ADD, OP_SUB:                 flags_nxt = ex_flag;
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_nxt = {flags[2:1], ex_flag[0]};
        default:                        flags_nxt = flags;
      endcase
    end
  end

`ifdef EX_FLAG_BYPASS_EN
  assign flag_src = flags_nxt;
`else
  assign flag_src = flags;
`endif

  // flag_src is {N,V,Z}
  always_comb begin
    cond_true = 1'b0;
    case (br_ccc)
      3'b000:  cond_true = ~flag_src[0];
      3'b001:  cond_true = flag_src[0];
      3'b010:  cond_true = ~flag_src[0] & ~flag_src[2];
      3'b011:  cond_true = flag_src[2];
      3'b100:  cond_true = flag_src[0] | (~flag_src[0] & ~flag_src[2]);
      3'b101:  cond_true = flag_src[2] | flag_src[0];
      3'b110:  cond_true = flag_src[1];
      default: cond_true = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid  <= 1'b0;
      mem_opcode <= '0;
      mem_result <= '0;
      mem_addr   <= '0;
      mem_rd     <= '0;
      mem_reg_we <= 1'b0;
      mem_mem_re <= 1'b0;
      mem_mem_we <= 1'b0;
    end else if (stall) begin
      mem_valid  <= mem_valid;
    end else if (flush) begin
      mem_valid  <= 1'b0;
      mem_opcode <= '0;
      mem_result <= '0;
      mem_addr   <= '0;
      mem_rd     <= '0;
      mem_reg_we <= 1'b0;
      mem_mem_re <= 1'b0;
      mem_mem_we <= 1'b0;
    end else begin
      mem_valid  <= cap_valid;
      mem_opcode <= ex_opcode;
      mem_result <= (ex_opcode == OP_PCS) ? ex_pcs_val : ex_result;
      mem_addr   <= ex_addr;
      mem_rd     <= ex_rd;
      mem_reg_we <= ex_reg_we & cap_valid;
      mem_mem_re <= ex_mem_re & cap_valid;
      mem_mem_we <= ex_mem_we & cap_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags  <= FLAG_RST;
      halted <= 1'b0;
    end else begin
      flags <= flags_nxt;
      if (accept && ex_opcode == OP_HLT) halted <= 1'b1;
    end
  end

endmodule
